// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter for N = 2**WIDTH requesters.
// Registers a binary grant index (grant_idx) for the downstream one-hot decoder.
// A grant is held until the owner pulses release_grant. An optional hold
// watchdog is compiled in by defining RR_GRANT_ARBITER_TIMEOUT_EN. It forces a
// release after MAX_HOLD GRANT cycles and pulses timeout for one cycle.
module rr_grant_arbiter #(
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2**WIDTH-1:0] req,
    input  logic                release_grant,
    output logic                grant_valid,
    output logic [WIDTH-1:0]    grant_idx,
    output logic                timeout
);

    localparam int N = 2**WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] last_ptr;
    logic [WIDTH-1:0] scan_idx;
    logic [WIDTH-1:0] win_idx;
    logic             win_found;
    logic             hold_expired;
    logic             grant_valid_next;
    logic             timeout_next;

    // The watchdog limit must leave at least one full cycle before the forced release.
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_grant_arbiter: MAX_HOLD must be at least 2");
    end

    // Round-robin scan. Start one past the last winner and wrap naturally in WIDTH bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = last_ptr + WIDTH'(k + 1);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;

    // Count GRANT cycles held without release. The count is zero while idle, so each grant starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else if (!release_grant) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_expired = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Arbitrate from IDLE, then leave GRANT on release or when the watchdog expires.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = GRANT;
            GRANT:   if (release_grant || hold_expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next output values. A watchdog release that coincides with a normal release does not raise timeout.
    always_comb begin
        grant_valid_next = (state_next == GRANT);
        timeout_next     = hold_expired && !release_grant;
    end

    // Registered outputs and the round-robin pointer. Only a fresh arbitration updates the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
            last_ptr    <= '1;
        end else begin
            grant_valid <= grant_valid_next;
            timeout     <= timeout_next;
            if (state == IDLE && win_found) begin
                grant_idx <= win_idx;
                last_ptr  <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Testbench for rr_grant_arbiter: directed scenarios followed by random traffic.
// Each clock edge, a reference model predicts the outputs and queues them.
// A monitor compares the queued prediction against the DUT on the falling edge.
module tb_rr_grant_arbiter;

    localparam int WIDTH    = 2;
    localparam int N        = 2**WIDTH;
    localparam int MAX_HOLD = 4;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic             valid;
        logic [WIDTH-1:0] idx;
        logic             to;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req   = '0;
    logic             rel   = 1'b0;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_idx;
    logic             timeout;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: whether a grant is held, who holds it, who won last, and how long it has been held.
    bit m_valid;
    int m_idx;
    int m_last;
    int m_hold;

    rr_grant_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .release_grant (rel),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = N - 1;
        m_hold  = 0;
    endtask

    // One clock edge of the arbiter's rules, using the inputs present at that edge.
    task automatic model_step(input logic [N-1:0] r, input logic rl);
        exp_t e;
        bit   to;
        bit   found;
        to    = 1'b0;
        found = 1'b0;
        if (!m_valid) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_last + 1 + k) % N;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_idx   = c;
                    m_last  = c;
                    m_valid = 1'b1;
                    m_hold  = 0;
                end
            end
        end else if (rl) begin
            m_valid = 1'b0;
        end else if (TO_EN && m_hold == MAX_HOLD - 1) begin
            m_valid = 1'b0;
            to      = 1'b1;
        end else begin
            m_hold++;
        end
        e.valid = m_valid;
        e.idx   = m_idx[WIDTH-1:0];
        e.to    = to;
        exp_q.push_back(e);
    endtask

    // Drive inputs on the falling edge, then predict the result of the next rising edge.
    task automatic step(input logic [N-1:0] r, input logic rl);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        model_step(r, rl);
    endtask

    // Assert reset between clock edges. Outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(grant_valid), 32'd0);
        check("async_rst_idx", 32'(grant_idx), 32'd0);
        check("async_rst_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the queued prediction, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_valid", 32'(grant_valid), 32'(e.valid));
                check("grant_idx", 32'(grant_idx), 32'(e.idx));
                check("timeout", 32'(timeout), 32'(e.to));
            end
        end
    end

    // Bound the total run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        logic         rl;

        #1;
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 0 wins first, then releases.
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b0);

        // Rotation with all requesting, releasing in the first GRANT cycle.
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
        end

        // Skip and wrap: last=2 with req=0011 gives 0, then last=0 gives 1.
        step(4'b0100, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0000, 1'b1);

        // Release seen in IDLE has no effect.
        step(4'b0000, 1'b1);

        // Hold: grant to 2, then req changes and release stays low (the watchdog fires when it is built in).
        step(4'b0100, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(4'b1000, 1'b0);
        end
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Reset in the middle of a grant, then req=1010 restarts from requester 1.
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        async_reset();
        step(4'b1010, 1'b0);
        step(4'b0000, 1'b1);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            rl = ($urandom_range(0, 2) == 0);
            step(r, rl);
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
        end

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
